// File: rtl/frame_parser.sv
// Byte-stream frame parser: locks on a sync word, reads a width/length header, packs BPP bytes per pixel
// and checks the end word. Pixel out one cycle after its last byte; a held output pixel stalls the input.
module frame_parser #(
  parameter int unsigned BPP       = 3,
  parameter int unsigned DIM_W     = 16,
  parameter logic [31:0] SYNC_WORD = 32'h4245_474E,
  parameter logic [31:0] END_WORD  = 32'h4245_4E44
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         axis_i_dat_i,
  input  logic               axis_i_vld_i,
  output logic               axis_i_rdy_o,
  output logic [8*BPP-1:0]   axis_o_dat_o,
  output logic               axis_o_vld_o,
  input  logic               axis_o_rdy_i,
  output logic               eol_o,
  output logic               line_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int unsigned IDX_W = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int unsigned PW    = 8 * BPP;

  typedef enum logic [2:0] {
    S_SYNC,
    S_WIDTH,
    S_LENGTH,
    S_DATA,
    S_DRAIN,
    S_TRAIL
  } state_t;

  state_t             state_q;
  logic [31:0]        shift_q;
  logic [31:0]        shift_d;
  logic [1:0]         hcnt_q;
  logic [DIM_W-1:0]   width_q;
  logic [DIM_W-1:0]   length_q;
  logic [DIM_W-1:0]   col_q;
  logic [DIM_W-1:0]   row_q;
  logic               width_big_q;
  logic [IDX_W-1:0]   idx_q;
  logic [PW-1:0]      asm_q;
  logic [PW-1:0]      asm_d;
  logic [PW-1:0]      dat_q;
  logic               vld_q;
  logic               eol_q;
  logic               done_q;
  logic               err_q;
  logic               in_rdy;
  logic               in_acc;
  logic               out_hs;
  logic               last_byte;
  logic               last_col;
  logic               last_row;

  always_comb begin
    in_rdy = 1'b0;
    unique case (state_q)
      S_SYNC, S_WIDTH, S_LENGTH, S_TRAIL: in_rdy = 1'b1;
      S_DATA:                             in_rdy = !vld_q || axis_o_rdy_i;
      default:                            in_rdy = 1'b0;
    endcase
  end

  assign shift_d   = {shift_q[23:0], axis_i_dat_i};
  assign in_acc    = axis_i_vld_i && in_rdy;
  assign out_hs    = vld_q && axis_o_rdy_i;
  assign last_byte = (idx_q == IDX_W'(BPP - 1));
  assign last_col  = (col_q == width_q - DIM_W'(1));
  assign last_row  = (row_q == length_q - DIM_W'(1));

  // First byte of a pixel lands in the MSB lane; the last byte completes asm_d.
  always_comb begin
    asm_d = asm_q;
    for (int b = 0; b < BPP; b++) begin
      if (idx_q == IDX_W'(BPP - 1 - b)) asm_d[8*b +: 8] = axis_i_dat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_SYNC;
      shift_q     <= '0;
      hcnt_q      <= '0;
      width_q     <= '0;
      length_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
      width_big_q <= 1'b0;
      idx_q       <= '0;
      asm_q       <= '0;
      dat_q       <= '0;
      vld_q       <= 1'b0;
      eol_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (in_acc) shift_q <= shift_d;
      if (out_hs) vld_q <= 1'b0;

      unique case (state_q)
        S_SYNC: begin
          if (in_acc && shift_d == SYNC_WORD) begin
            state_q <= S_WIDTH;
            hcnt_q  <= '0;
          end
        end
        S_WIDTH: begin
          if (in_acc) begin
            hcnt_q <= hcnt_q + 2'd1;
            if (hcnt_q == 2'd3) begin
              width_q     <= shift_d[DIM_W-1:0];
              width_big_q <= |shift_d[31:DIM_W];
              state_q     <= S_LENGTH;
            end
          end
        end
        S_LENGTH: begin
          if (in_acc) begin
            hcnt_q <= hcnt_q + 2'd1;
            if (hcnt_q == 2'd3) begin
              length_q <= shift_d[DIM_W-1:0];
              // An empty frame goes straight to trailer checking, before any range test.
              if ((width_q == '0 && !width_big_q) || shift_d == 32'h0) begin
                state_q <= S_TRAIL;
                shift_q <= '0;
              end else if (width_big_q || |shift_d[31:DIM_W]) begin
                err_q   <= 1'b1;
                state_q <= S_SYNC;
                shift_q <= '0;
              end else begin
                col_q   <= '0;
                row_q   <= '0;
                idx_q   <= '0;
                state_q <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (in_acc) begin
            asm_q <= asm_d;
            if (last_byte) begin
              idx_q <= '0;
              dat_q <= asm_d;
              eol_q <= last_col;
              vld_q <= 1'b1;
              if (last_col) begin
                col_q <= '0;
                row_q <= row_q + DIM_W'(1);
                if (last_row) state_q <= S_DRAIN;
              end else begin
                col_q <= col_q + DIM_W'(1);
              end
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (!vld_q || axis_o_rdy_i) begin
            state_q <= S_TRAIL;
            shift_q <= '0;
          end
        end
        S_TRAIL: begin
          if (in_acc) begin
            if (shift_d == END_WORD) begin
              done_q  <= 1'b1;
              state_q <= S_SYNC;
              shift_q <= '0;
            end else if (shift_d == SYNC_WORD) begin
              err_q   <= 1'b1;
              state_q <= S_WIDTH;
              hcnt_q  <= '0;
            end
          end
        end
        default: state_q <= S_SYNC;
      endcase
    end
  end

  assign axis_i_rdy_o = in_rdy;
  assign axis_o_dat_o = dat_q;
  assign axis_o_vld_o = vld_q;
  assign eol_o        = eol_q;
  assign line_o       = vld_q && axis_o_rdy_i && eol_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
